mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width and meaning:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- ex_wd  in  5  destination register address from EX/MEM
- ex_wreg  in  1  register-write enable from EX/MEM
- ex_wdata  in  32  ALU result from EX/MEM
- ex_whilo  in  1  HI/LO write enable from EX/MEM
- ex_hi  in  32  HI value from EX/MEM
- ex_lo  in  32  LO value from EX/MEM
- ex_aluop  in  8  operation code; LB, LBU, LH, LHU, LW, SB, SH, SW are memory ops, all others are non-memory
- ex_mem_addr  in  32  effective byte address
- ex_reg2  in  32  store source data
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo  out  5/1/32/1/32/32  results to MEM/WB
- dbus_req  out  1  data-bus request
- dbus_we  out  1  write strobe: 1 store, 0 load
- dbus_sel  out  4  byte-lane enables; bit3 = bits 31:24
- dbus_addr  out  32  word address: ex_mem_addr with bits 1:0 forced to 0
- dbus_wdata  out  32  lane-replicated store data
- dbus_ack  in  1  one-cycle completion pulse
- dbus_rdata  in  32  read data, valid while dbus_ack=1
- stall_req  out  1  hold EX/MEM and earlier stages
- misalign_err  out  1  misaligned-access flag

Function
REQ-002 The block SHALL use a three-state FSM with states IDLE, BUSY and DONE.
REQ-003 In IDLE with a non-memory op, outputs SHALL pass through combinationally (mem_* = ex_*), with stall_req=0 and zero added latency.
REQ-004 In IDLE with an aligned memory op, the block SHALL set stall_req=1, mem_wreg=0 and mem_whilo=0 (bubble), and go to BUSY on the next edge.
REQ-005 In BUSY, dbus_req SHALL be 1, and dbus_we, dbus_sel, dbus_addr and dbus_wdata SHALL stay stable, derived from the held EX/MEM inputs.
REQ-006 In BUSY, stall_req SHALL be 1 and mem_wreg=mem_whilo=0.
REQ-007 In BUSY with dbus_ack=1, the block SHALL capture dbus_rdata into a 32-bit load buffer and go to DONE.
REQ-008 With no ack, BUSY SHALL persist indefinitely.
REQ-009 In DONE, the block SHALL set dbus_req=0, stall_req=0, mem_wd=ex_wd and mem_wreg=ex_wreg.
REQ-010 In DONE, mem_wdata SHALL be the formatted load result for a load, or ex_wdata for a store.
REQ-011 In DONE, mem_whilo, mem_hi and mem_lo SHALL pass through.
REQ-012 DONE SHALL always go to IDLE on the next edge. Memory-op latency is therefore 3 cycles minimum, and 2 cycles plus the ack wait in general.
REQ-013 Lane mapping SHALL be big-endian:
- byte at addr[1:0]=0 uses bits 31:24 with sel 1000; addr 3 uses bits 7:0 with sel 0001
- halfword at addr[1]=0 uses bits 31:16 with sel 1100, otherwise sel 0011
- word uses sel 1111
REQ-014 Store data SHALL be replicated: SB as {4{reg2[7:0]}}, SH as {2{reg2[15:0]}}, SW as reg2.
REQ-015 LB and LH SHALL sign-extend the selected lane; LBU and LHU SHALL zero-extend it.
REQ-016 A misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0) in IDLE SHALL issue no bus access, set stall_req=0, set misalign_err=1 for that cycle only, and set mem_wreg=0.
REQ-017 dbus_ack SHALL be ignored in IDLE and DONE.
REQ-018 dbus_req SHALL be 0 in IDLE and DONE.

Reset
REQ-019 When rst=1 at an edge, state SHALL go to IDLE and the load buffer SHALL clear to 0.
REQ-020 During reset, stall_req=0, dbus_req=0, misalign_err=0, mem_wreg=0 and mem_whilo=0.
REQ-021 A reset in BUSY SHALL abandon the access with no write-back, and a late ack SHALL be ignored.

Structure
REQ-022 The aluop codes for the eight memory ops, and the state encodings, SHALL reside in the shared define include.
REQ-023 Lane select, extension and store replication SHALL be one combinational sub-module, mem_align; the FSM and load buffer SHALL remain in mem_access.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Non-memory op with ex_wdata=0x12345678 and ex_wreg=1 -> same-cycle mem_wdata=0x12345678, stall_req=0.
- LB at addr 0x101, ack after 2 BUSY cycles with rdata=0x0080FF00 -> dbus_sel=0100, mem_wdata=0xFFFFFF80 in DONE; stall_req high for 3 cycles.
- LHU at addr 0x202 with rdata=0xAAAA8001 -> sel=0011, mem_wdata=0x00008001.
- SB at addr 0x3 with reg2=0x000000A5 -> dbus_we=1, sel=0001, dbus_wdata=0xA5A5A5A5, addr=0x0.
- LW at addr 0x6 -> misalign_err pulses once, dbus_req never asserts, mem_wreg=0, no stall.
- Reset asserted during BUSY, then ack arrives -> state IDLE, no write-back, dbus_req=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: memory-op aluop codes, FSM state encoding and op classification helper.
package mem_access_pkg;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  function automatic logic is_mem_op(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: EX/MEM inputs, MEM/WB results and data-bus signals of the memory stage.
interface mem_access_if;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall_req;
  logic        misalign_err;
  modport slave (
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
    input  dbus_ack, dbus_rdata,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata, stall_req, misalign_err
  );
  modport master (
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
    output dbus_ack, dbus_rdata,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata, stall_req, misalign_err
  );
endinterface

// File: rtl/mem_align.sv
// mem_align: big-endian lane select, store replication, load extension and alignment check.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        mem_o,
  output logic        store_o,
  output logic        misalign_o
);
  logic byte_op, half_op, word_op, sign_op;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    byte_op    = aluop_i inside {OP_LB, OP_LBU, OP_SB};
    half_op    = aluop_i inside {OP_LH, OP_LHU, OP_SH};
    word_op    = aluop_i inside {OP_LW, OP_SW};
    sign_op    = aluop_i inside {OP_LB, OP_LH};
    mem_o      = is_mem_op(aluop_i);
    store_o    = aluop_i inside {OP_SB, OP_SH, OP_SW};
    misalign_o = (half_op && off_i[0]) || (word_op && off_i != 2'd0);
    sel_o      = byte_op ? 4'b1000 >> off_i : half_op ? (off_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wdata_o    = byte_op ? {4{reg2_i[7:0]}} : half_op ? {2{reg2_i[15:0]}} : reg2_i;
    b          = off_i == 2'd0 ? rdata_i[31:24] : off_i == 2'd1 ? rdata_i[23:16] :
                 off_i == 2'd2 ? rdata_i[15:8] : rdata_i[7:0];
    h          = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    load_o     = byte_op ? {{24{sign_op & b[7]}}, b} :
                 half_op ? {{16{sign_op & h[15]}}, h} : rdata_i;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage; stalls the pipeline across a data-bus transaction and formats loads.
module mem_access
  import mem_access_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);
  state_e      state_q, state_d;
  logic [31:0] lbuf_q, lbuf_d;
  logic [3:0]  sel;
  logic [31:0] st_data, ld_data;
  logic        mem_op, store_op, misalign;
  mem_align u_align (
    .aluop_i   (bus.ex_aluop),
    .off_i     (bus.ex_mem_addr[1:0]),
    .reg2_i    (bus.ex_reg2),
    .rdata_i   (lbuf_q),
    .sel_o     (sel),
    .wdata_o   (st_data),
    .load_o    (ld_data),
    .mem_o     (mem_op),
    .store_o   (store_op),
    .misalign_o(misalign)
  );
  // Bus address/data follow the EX/MEM inputs, which the stall holds steady during BUSY.
  assign bus.dbus_we    = store_op;
  assign bus.dbus_sel   = sel;
  assign bus.dbus_addr  = {bus.ex_mem_addr[31:2], 2'b00};
  assign bus.dbus_wdata = st_data;
  always_comb begin
    state_d          = state_q;
    lbuf_d           = lbuf_q;
    bus.mem_wd       = bus.ex_wd;
    bus.mem_wreg     = bus.ex_wreg;
    bus.mem_wdata    = bus.ex_wdata;
    bus.mem_whilo    = bus.ex_whilo;
    bus.mem_hi       = bus.ex_hi;
    bus.mem_lo       = bus.ex_lo;
    bus.dbus_req     = 1'b0;
    bus.stall_req    = 1'b0;
    bus.misalign_err = 1'b0;
    if (state_q == IDLE && mem_op && misalign) begin
      bus.misalign_err = 1'b1;
      bus.mem_wreg     = 1'b0;
    end else if (state_q == IDLE && mem_op) begin
      bus.stall_req = 1'b1;
      bus.mem_wreg  = 1'b0;
      bus.mem_whilo = 1'b0;
      state_d       = BUSY;
    end else if (state_q == BUSY) begin
      bus.dbus_req  = 1'b1;
      bus.stall_req = 1'b1;
      bus.mem_wreg  = 1'b0;
      bus.mem_whilo = 1'b0;
      lbuf_d        = bus.dbus_ack ? bus.dbus_rdata : lbuf_q;
      state_d       = bus.dbus_ack ? DONE : BUSY;
    end else if (state_q == DONE) begin
      bus.mem_wdata = store_op ? bus.ex_wdata : ld_data;
      state_d       = IDLE;
    end
    if (rst) begin
      bus.dbus_req     = 1'b0;
      bus.stall_req    = 1'b0;
      bus.misalign_err = 1'b0;
      bus.mem_wreg     = 1'b0;
      bus.mem_whilo    = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      lbuf_q  <= lbuf_d;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scenario tasks with a scoreboard of expected MEM/WB results.
module tb_mem_access;
  import mem_access_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  logic req_seen = 1'b0;
  logic watch_req = 1'b0;
  mem_access_if bus ();
  mem_access dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (watch_req && bus.dbus_req) req_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_aluop    = OP_NOP;
    bus.ex_wd       = 5'd3;
    bus.ex_wreg     = 1'b0;
    bus.ex_wdata    = 32'h0;
    bus.ex_whilo    = 1'b0;
    bus.ex_hi       = 32'h0;
    bus.ex_lo       = 32'h0;
    bus.ex_mem_addr = 32'h0;
    bus.ex_reg2     = 32'h0;
    bus.dbus_ack    = 1'b0;
    bus.dbus_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    bus.ex_aluop = OP_LW; bus.ex_mem_addr = 32'h40; bus.ex_wreg = 1'b1; bus.ex_whilo = 1'b1;
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b exp 0", bus.stall_req); end
    vectors++;
    if (bus.dbus_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", bus.dbus_req); end
    vectors++;
    if (bus.mem_wreg !== 1'b0 || bus.mem_whilo !== 1'b0 || bus.misalign_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_wb got wreg=%b whilo=%b mis=%b exp 000", bus.mem_wreg, bus.mem_whilo, bus.misalign_err);
    end
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough(input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo);
    bus.ex_aluop = 8'h21; bus.ex_wd = 5'd9; bus.ex_wreg = 1'b1; bus.ex_wdata = wdata;
    bus.ex_whilo = 1'b1; bus.ex_hi = hi; bus.ex_lo = lo;
    sb.push_back(wdata);
    #1;
    vectors++;
    if (bus.mem_wdata !== sb.pop_front()) begin miscompares++; $display("FAIL pass_wdata got %h exp %h", bus.mem_wdata, wdata); end
    vectors++;
    if (bus.stall_req !== 1'b0 || bus.mem_wreg !== 1'b1 || bus.mem_wd !== 5'd9) begin
      miscompares++; $display("FAIL pass_ctrl got stall=%b wreg=%b wd=%0d exp 0 1 9", bus.stall_req, bus.mem_wreg, bus.mem_wd);
    end
    vectors++;
    if (bus.mem_whilo !== 1'b1 || bus.mem_hi !== hi || bus.mem_lo !== lo) begin
      miscompares++; $display("FAIL pass_hilo got %b %h %h exp 1 %h %h", bus.mem_whilo, bus.mem_hi, bus.mem_lo, hi, lo);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int ack_at, input logic [3:0] sel_e,
                          input logic we_e, input logic [31:0] bus_wd_e, input logic [31:0] res_e,
                          input int stalls_e);
    int busy = 0;
    int stalls = 0;
    bus.ex_aluop = op; bus.ex_mem_addr = addr; bus.ex_reg2 = reg2;
    bus.ex_wd = 5'd7; bus.ex_wreg = 1'b1; bus.ex_wdata = 32'h0BAD_F00D;
    sb.push_back(res_e);
    #1;
    vectors++;
    if (bus.mem_wreg !== 1'b0) begin miscompares++; $display("FAIL bubble_wreg got %b exp 0", bus.mem_wreg); end
    for (int i = 0; i < 50 && bus.stall_req === 1'b1; i++) begin
      stalls++;
      tick();
      bus.dbus_ack = 1'b0;
      if (bus.dbus_req === 1'b1) begin
        busy++;
        vectors++;
        if (bus.dbus_sel !== sel_e || bus.dbus_we !== we_e || bus.dbus_addr !== {addr[31:2], 2'b00} ||
            (we_e && bus.dbus_wdata !== bus_wd_e) || bus.mem_wreg !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_bus op=%h got sel=%b we=%b addr=%h wd=%h wreg=%b exp sel=%b we=%b addr=%h wd=%h wreg=0",
                   op, bus.dbus_sel, bus.dbus_we, bus.dbus_addr, bus.dbus_wdata, bus.mem_wreg,
                   sel_e, we_e, {addr[31:2], 2'b00}, bus_wd_e);
        end
        if (busy == ack_at) begin bus.dbus_ack = 1'b1; bus.dbus_rdata = rdata; end
        #1;
      end
    end
    vectors++;
    if (stalls !== stalls_e) begin miscompares++; $display("FAIL stall_cycles op=%h got %0d exp %0d", op, stalls, stalls_e); end
    vectors++;
    if (bus.dbus_req !== 1'b0 || bus.mem_wreg !== 1'b1 || bus.mem_wd !== 5'd7) begin
      miscompares++; $display("FAIL done_ctrl op=%h got req=%b wreg=%b wd=%0d exp 0 1 7", op, bus.dbus_req, bus.mem_wreg, bus.mem_wd);
    end
    vectors++;
    if (bus.mem_wdata !== sb[0]) begin miscompares++; $display("FAIL done_wdata op=%h got %h exp %h", op, bus.mem_wdata, sb[0]); end
    void'(sb.pop_front());
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.stall_req !== 1'b0 || bus.dbus_req !== 1'b0) begin
      miscompares++; $display("FAIL back_idle got stall=%b req=%b exp 0 0", bus.stall_req, bus.dbus_req);
    end
  endtask

  task automatic test_misalign();
    req_seen = 1'b0; watch_req = 1'b1;
    bus.ex_aluop = OP_LW; bus.ex_mem_addr = 32'h6; bus.ex_wreg = 1'b1;
    #1;
    vectors++;
    if (bus.misalign_err !== 1'b1 || bus.stall_req !== 1'b0 || bus.mem_wreg !== 1'b0) begin
      miscompares++; $display("FAIL misalign_flag got mis=%b stall=%b wreg=%b exp 1 0 0", bus.misalign_err, bus.stall_req, bus.mem_wreg);
    end
    tick();
    idle_inputs();
    #1;
    vectors++;
    if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL misalign_pulse got %b exp 0", bus.misalign_err); end
    bus.ex_aluop = OP_SH; bus.ex_mem_addr = 32'h11;
    #1;
    vectors++;
    if (bus.misalign_err !== 1'b1 || bus.stall_req !== 1'b0) begin
      miscompares++; $display("FAIL misalign_sh got mis=%b stall=%b exp 1 0", bus.misalign_err, bus.stall_req);
    end
    tick();
    idle_inputs();
    tick();
    tick();
    watch_req = 1'b0;
    vectors++;
    if (req_seen !== 1'b0) begin miscompares++; $display("FAIL misalign_noreq got %b exp 0", req_seen); end
  endtask

  task automatic test_reset_busy();
    bus.ex_aluop = OP_LW; bus.ex_mem_addr = 32'h10; bus.ex_wreg = 1'b1;
    tick();
    vectors++;
    if (bus.dbus_req !== 1'b1) begin miscompares++; $display("FAIL rb_busy got req=%b exp 1", bus.dbus_req); end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.dbus_req !== 1'b0 || bus.stall_req !== 1'b0 || bus.mem_wreg !== 1'b0) begin
      miscompares++; $display("FAIL rb_during got req=%b stall=%b wreg=%b exp 000", bus.dbus_req, bus.stall_req, bus.mem_wreg);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hFFFF_FFFF;
    tick();
    bus.dbus_ack = 1'b0;
    vectors++;
    if (bus.dbus_req !== 1'b0 || bus.stall_req !== 1'b0 || bus.mem_wreg !== 1'b0) begin
      miscompares++; $display("FAIL rb_late_ack got req=%b stall=%b wreg=%b exp 000", bus.dbus_req, bus.stall_req, bus.mem_wreg);
    end
    test_passthrough(32'hCAFE_0001, 32'h1, 32'h2);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_passthrough(32'h1234_5678, 32'hAAAA_0000, 32'h0000_5555);
    test_mem(OP_LB,  32'h101, 32'h0, 32'h0080_FF00, 2, 4'b0100, 1'b0, 32'h0, 32'hFFFF_FF80, 3);
    test_mem(OP_LHU, 32'h202, 32'h0, 32'hAAAA_8001, 1, 4'b0011, 1'b0, 32'h0, 32'h0000_8001, 2);
    test_mem(OP_SB,  32'h3,   32'hA5, 32'h0, 1, 4'b0001, 1'b1, 32'hA5A5_A5A5, 32'h0BAD_F00D, 2);
    test_mem(OP_LH,  32'h0,   32'h0, 32'h8123_4567, 3, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8123, 4);
    test_mem(OP_LBU, 32'h7,   32'h0, 32'h0000_00F0, 1, 4'b0001, 1'b0, 32'h0, 32'h0000_00F0, 2);
    test_mem(OP_LB,  32'h0,   32'h0, 32'h7F00_0000, 1, 4'b1000, 1'b0, 32'h0, 32'h0000_007F, 2);
    test_mem(OP_SH,  32'h2,   32'h1234_BEEF, 32'h0, 2, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0BAD_F00D, 3);
    test_mem(OP_SW,  32'h8,   32'h1122_3344, 32'h0, 1, 4'b1111, 1'b1, 32'h1122_3344, 32'h0BAD_F00D, 2);
    test_mem(OP_LW,  32'h4,   32'h0, 32'hCAFE_BABE, 1, 4'b1111, 1'b0, 32'h0, 32'hCAFE_BABE, 2);
    test_misalign();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
